// File: rtl/dds_key_ctrl.sv
// Key-driven DDS parameter controller: tuning word, waveform select and step size.
// Optional DDS_PHASE_RST_EN: a waveform change also clears the phase accumulator.
module dds_key_ctrl #(
    parameter int unsigned               FW_WIDTH  = 32,
    parameter logic [FW_WIDTH-1:0]       F_INIT    = 85899,
    parameter logic [FW_WIDTH-1:0]       F_MIN     = 859,
    parameter logic [FW_WIDTH-1:0]       F_MAX     = 32'h4000_0000,
    parameter logic [FW_WIDTH-1:0]       STEP_BASE = 859
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_up,
    input  logic                key_dn,
    input  logic                key_step,
    input  logic                key_wave,
    output logic [FW_WIDTH-1:0] freq_word,
    output logic [1:0]          wave_sel,
    output logic [1:0]          step_idx,
    output logic                upd,
    output logic                phase_rst
);

    typedef enum logic [1:0] {IDLE, CALC, CLAMP} state_t;
    typedef enum logic [1:0] {CMD_UP, CMD_DN, CMD_STEP, CMD_WAVE} cmd_t;

    state_t              state, state_nxt;
    cmd_t                cmd, cmd_in;
    logic                any_key;
    logic [FW_WIDTH:0]   step_size;
    logic [FW_WIDTH:0]   cand;
    logic [FW_WIDTH-1:0] freq_nxt;
    logic [1:0]          wave_nxt;
    logic [1:0]          step_nxt;
    logic                upd_nxt;
    logic                prst_nxt;

    assign any_key   = key_up | key_dn | key_step | key_wave;
    assign step_size = {1'b0, STEP_BASE} << {step_idx, 2'b00};

    always_comb begin
        cmd_in = CMD_WAVE;
        if (key_up)        cmd_in = CMD_UP;
        else if (key_dn)   cmd_in = CMD_DN;
        else if (key_step) cmd_in = CMD_STEP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_key) state_nxt = CALC;
            CALC:    state_nxt = CLAMP;
            CLAMP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Carry/borrow live in cand[FW_WIDTH]; both operands are zero-extended.
    always_comb begin
        freq_nxt = freq_word;
        wave_nxt = wave_sel;
        step_nxt = step_idx;
        upd_nxt  = 1'b0;
        prst_nxt = 1'b0;
        if (state == CLAMP) begin
            case (cmd)
                CMD_UP: begin
                    if (cand[FW_WIDTH] || (cand[FW_WIDTH-1:0] > F_MAX)) freq_nxt = F_MAX;
                    else                                               freq_nxt = cand[FW_WIDTH-1:0];
                    upd_nxt = (freq_nxt != freq_word);
                end
                CMD_DN: begin
                    if (cand[FW_WIDTH] || (cand[FW_WIDTH-1:0] < F_MIN)) freq_nxt = F_MIN;
                    else                                               freq_nxt = cand[FW_WIDTH-1:0];
                    upd_nxt = (freq_nxt != freq_word);
                end
                CMD_STEP: step_nxt = step_idx + 2'd1;
                default: begin
                    wave_nxt = wave_sel + 2'd1;
                    upd_nxt  = 1'b1;
                    prst_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd       <= CMD_UP;
            cand      <= '0;
            freq_word <= F_INIT;
            wave_sel  <= '0;
            step_idx  <= '0;
            upd       <= 1'b0;
        end else begin
            if (state == IDLE && any_key) cmd <= cmd_in;
            if (state == CALC) begin
                if (cmd == CMD_DN) cand <= {1'b0, freq_word} - step_size;
                else               cand <= {1'b0, freq_word} + step_size;
            end
            freq_word <= freq_nxt;
            wave_sel  <= wave_nxt;
            step_idx  <= step_nxt;
            upd       <= upd_nxt;
        end
    end

`ifdef DDS_PHASE_RST_EN
    logic phase_rst_q;
    always_ff @(posedge clk) begin
        if (!rst_n) phase_rst_q <= 1'b0;
        else        phase_rst_q <= prst_nxt;
    end
    assign phase_rst = phase_rst_q;
`else
    logic prst_unused;
    assign prst_unused = prst_nxt;
    assign phase_rst   = 1'b0;
`endif

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Scoreboard bench for dds_key_ctrl: a behavioural model pushes expected outputs
// per key command; each scenario task pops and compares once the result is due.
module tb_dds_key_ctrl;

    localparam longint FMAX = 64'h4000_0000;
    localparam longint FMIN = 859;
    localparam longint FINI = 85899;
`ifdef DDS_PHASE_RST_EN
    localparam bit PRST = 1'b1;
`else
    localparam bit PRST = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] f;
        logic [1:0]  w;
        logic [1:0]  s;
        logic        u;
        logic        p;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_up = 1'b0, key_dn = 1'b0, key_step = 1'b0, key_wave = 1'b0;
    logic [31:0] freq_word;
    logic [1:0]  wave_sel, step_idx;
    logic        upd, phase_rst;

    obs_t   sb[$];
    obs_t   e, a;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint mf;
    int     mw, ms;

    dds_key_ctrl #(
        .FW_WIDTH (32),
        .F_INIT   (32'd85899),
        .F_MIN    (32'd859),
        .F_MAX    (32'h4000_0000),
        .STEP_BASE(32'd859)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_up   (key_up),
        .key_dn   (key_dn),
        .key_step (key_step),
        .key_wave (key_wave),
        .freq_word(freq_word),
        .wave_sel (wave_sel),
        .step_idx (step_idx),
        .upd      (upd),
        .phase_rst(phase_rst)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic obs_t observe();
        observe = '{freq_word, wave_sel, step_idx, upd, phase_rst};
    endfunction

    function automatic void model_reset();
        mf = FINI; mw = 0; ms = 0;
        sb.push_back('{32'(FINI), 2'd0, 2'd0, 1'b0, 1'b0});
    endfunction

    // k: 0 up, 1 down, 2 step, 3 wave
    function automatic void model_cmd(input int k);
        longint stp = 64'd859 << (4 * ms);
        longint nf = mf;
        bit u = 1'b0, p = 1'b0;
        case (k)
            0: begin nf = (mf + stp > FMAX) ? FMAX : mf + stp; u = (nf != mf); end
            1: begin nf = (stp > mf || mf - stp < FMIN) ? FMIN : mf - stp; u = (nf != mf); end
            2: ms = (ms + 1) % 4;
            default: begin mw = (mw + 1) % 4; u = 1'b1; p = PRST; end
        endcase
        mf = nf;
        sb.push_back('{32'(mf), 2'(mw), 2'(ms), u, p});
    endfunction

    // Pulse at edge N, return #1 after edge N+2. also_dn: coincident down key;
    // late_dn: down key sampled at N+1 while the controller is busy.
    task automatic pulse(input int k, input bit also_dn, input bit late_dn);
        model_cmd(k);
        @(negedge clk);
        key_up = (k == 0); key_dn = (k == 1) | also_dn; key_step = (k == 2); key_wave = (k == 3);
        @(posedge clk);
        @(negedge clk);
        key_up = 1'b0; key_dn = late_dn; key_step = 1'b0; key_wave = 1'b0;
        @(posedge clk);
        @(negedge clk);
        key_dn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL reset: got %p expected %p", a, e); end
    endtask

    task automatic test_single_up();
        pulse(0, 1'b0, 1'b0);
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e || a.f !== 32'd86758) begin n_bad++; $display("FAIL single_up: got %p expected %p", a, e); end
        @(posedge clk); #1;
        n_cmp++;
        if (upd !== 1'b0) begin n_bad++; $display("FAIL single_up_upd_width: got upd=%b expected 0", upd); end
    endtask

    task automatic test_priority_busy();
        pulse(0, 1'b1, 1'b0);
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL priority_up_dn: got %p expected %p", a, e); end
        pulse(0, 1'b0, 1'b1);
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL busy_ignore: got %p expected %p", a, e); end
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (freq_word !== 32'(mf) || upd !== 1'b0) begin
            n_bad++; $display("FAIL busy_no_late_cmd: got f=%0d upd=%b expected f=%0d upd=0", freq_word, upd, mf);
        end
    endtask

    task automatic test_wave_wrap();
        for (int i = 0; i < 4; i++) begin
            pulse(3, 1'b0, 1'b0);
            e = sb.pop_front(); a = observe(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL wave_wrap[%0d]: got %p expected %p", i, a, e); end
        end
    endtask

    task automatic test_reset_in_clamp();
        @(negedge clk); key_up = 1'b1;
        @(posedge clk);
        @(negedge clk); key_up = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL reset_in_clamp: got %p expected %p", a, e); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (upd !== 1'b0 || freq_word !== 32'(FINI)) begin
            n_bad++; $display("FAIL reset_in_clamp_after: got f=%0d upd=%b expected f=%0d upd=0", freq_word, upd, FINI);
        end
    endtask

    task automatic test_lower_sat();
        pulse(2, 1'b0, 1'b0);
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL lower_step1: got %p expected %p", a, e); end
        for (int i = 1; i <= 8; i++) begin
            pulse(1, 1'b0, 1'b0);
            e = sb.pop_front(); a = observe(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL lower_dn[%0d]: got %p expected %p", i, a, e); end
        end
        n_cmp++;
        if (freq_word !== 32'd859 || mf != 859) begin
            n_bad++; $display("FAIL lower_floor: got %0d expected 859", freq_word);
        end
    endtask

    task automatic test_upper_sat();
        int guard = 0;
        for (int i = 0; i < 2; i++) begin
            pulse(2, 1'b0, 1'b0);
            e = sb.pop_front(); a = observe(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL upper_step[%0d]: got %p expected %p", i, a, e); end
        end
        while (mf != FMAX && guard < 400) begin
            guard++;
            pulse(0, 1'b0, 1'b0);
            e = sb.pop_front(); a = observe(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL upper_up[%0d]: got %p expected %p", guard, a, e); end
        end
        n_cmp++;
        if (freq_word !== 32'h4000_0000 || upd !== 1'b1) begin
            n_bad++; $display("FAIL upper_clamp: got f=%h upd=%b expected f=40000000 upd=1", freq_word, upd);
        end
        pulse(0, 1'b0, 1'b0);
        e = sb.pop_front(); a = observe(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL upper_noop: got %p expected %p", a, e); end
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_priority_busy();
        test_wave_wrap();
        test_reset_in_clamp();
        test_lower_sat();
        test_upper_sat();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
